// File: rtl/if_id_skid_queue.sv
// if_id_skid_queue: multi-lane IF/ID circular queue with valid/ready handshake, flush and per-lane field decode
module if_id_skid_queue #(
    parameter int PC_WIDTH       = 32,
    parameter int INST_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LANES          = 2,
    parameter int DEPTH          = 2,
    localparam int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [PC_WIDTH-1:0]                in_pc,
    input  logic [PC_WIDTH-1:0]                in_pc_next,
    input  logic [LANES*INST_WIDTH-1:0]        in_inst,
    input  logic [LANES-1:0]                   in_lane_mask,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [PC_WIDTH-1:0]                out_pc,
    output logic [PC_WIDTH-1:0]                out_pc_next,
    output logic [LANES*INST_WIDTH-1:0]        out_inst,
    output logic [LANES-1:0]                   out_lane_mask,
    output logic [LANES*7-1:0]                 out_opcode,
    output logic [LANES*REG_ADDR_WIDTH-1:0]    out_rs1,
    output logic [LANES*REG_ADDR_WIDTH-1:0]    out_rs2,
    output logic [LANES*REG_ADDR_WIDTH-1:0]    out_rd,
    output logic [CNT_W-1:0]                   occupancy
);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [PC_WIDTH-1:0]         pc_q      [DEPTH];
    logic [PC_WIDTH-1:0]         pc_next_q [DEPTH];
    logic [LANES*INST_WIDTH-1:0] inst_q    [DEPTH];
    logic [LANES-1:0]            mask_q    [DEPTH];
    logic [PTR_W-1:0]            wr_ptr, rd_ptr;
    logic [CNT_W-1:0]            count;
    logic                        push, pop;
    assign in_ready  = count != CNT_W'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign occupancy = count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                pc_q[k]      <= '0;
                pc_next_q[k] <= '0;
                inst_q[k]    <= '0;
                mask_q[k]    <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_q[wr_ptr]      <= in_pc;
                pc_next_q[wr_ptr] <= in_pc_next;
                inst_q[wr_ptr]    <= in_inst;
                mask_q[wr_ptr]    <= in_lane_mask;
                wr_ptr            <= wr_ptr == PTR_W'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr == PTR_W'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            if (push & ~pop)
                count <= count + 1'b1;
            else if (pop & ~push)
                count <= count - 1'b1;
        end
    end
    always_comb begin
        out_pc        = out_valid ? pc_q[rd_ptr]      : '0;
        out_pc_next   = out_valid ? pc_next_q[rd_ptr] : '0;
        out_inst      = out_valid ? inst_q[rd_ptr]    : '0;
        out_lane_mask = out_valid ? mask_q[rd_ptr]    : '0;
    end
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign out_opcode[i*7 +: 7]                        = out_inst[i*INST_WIDTH +: 7];
        assign out_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]  = out_inst[i*INST_WIDTH + 7 +: REG_ADDR_WIDTH];
        assign out_rs1[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] = out_inst[i*INST_WIDTH + 15 +: REG_ADDR_WIDTH];
        assign out_rs2[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] = out_inst[i*INST_WIDTH + 20 +: REG_ADDR_WIDTH];
    end
endmodule
